// File: rtl/sort_arb_pkg.sv
// Shared types and width helpers for the packet arbiter in front of main_sort.
// No logic; imported by the arbiter and its round-robin picker.
package sort_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } arb_state_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter must be able to hold MAX_PKT_LEN-1 with headroom for the +1 compare.
  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, ascending with wrap.
// Zero latency; outputs a one-hot grant (all-zero when nothing requests) and its index.
module rr_arbiter
  import sort_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = ch_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr_i) + i) % N);
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/sort_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one sorter sink among NUM_SRC requesters.
// 0-cycle datapath, 1-cycle arbitration; src_ready_i passes straight to the granted snk_ready_o.
module sort_pkt_arbiter
  import sort_arb_pkg::*;
#(
  parameter int DWIDTH      = 8,
  parameter int NUM_SRC     = 4,
  parameter int MAX_PKT_LEN = 16,
  parameter int CH_W        = ch_w(NUM_SRC)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC*DWIDTH-1:0] snk_data_i,
  input  logic [NUM_SRC-1:0]        snk_startofpacket_i,
  input  logic [NUM_SRC-1:0]        snk_endofpacket_i,
  input  logic [NUM_SRC-1:0]        snk_valid_i,
  output logic [NUM_SRC-1:0]        snk_ready_o,
  output logic [DWIDTH-1:0]         src_data_o,
  output logic                      src_startofpacket_o,
  output logic                      src_endofpacket_o,
  output logic                      src_valid_o,
  input  logic                      src_ready_i,
  output logic [CH_W-1:0]           src_channel_o,
  output logic                      busy_o,
  output logic                      trunc_o
);

  localparam int                CNT_W    = cnt_w(MAX_PKT_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_PKT_LEN - 1);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_SRC - 1);

  arb_state_t         state_q, state_d;
  logic [CH_W-1:0]    grant_q, grant_d;
  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               trunc_q, trunc_d;

  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] pick_gnt;
  logic [CH_W-1:0]    pick_idx;
  logic [CH_W-1:0]    g_next;
  logic               g_vld, g_eop;
  logic [DWIDTH-1:0]  data_arr [NUM_SRC];

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_split
    assign data_arr[k] = snk_data_i[k*DWIDTH +: DWIDTH];
  end

  assign cand = snk_valid_i & snk_startofpacket_i;

  rr_arbiter #(.N(NUM_SRC), .IW(CH_W)) u_rr (
    .req_i (cand),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign g_vld  = snk_valid_i[grant_q];
  assign g_eop  = snk_endofpacket_i[grant_q];
  assign g_next = (grant_q == CH_LAST) ? '0 : grant_q + CH_W'(1);

  always_comb begin
    state_d             = state_q;
    grant_d             = grant_q;
    ptr_d               = ptr_q;
    cnt_d               = cnt_q;
    trunc_d             = 1'b0;
    snk_ready_o         = '0;
    src_valid_o         = 1'b0;
    src_data_o          = '0;
    src_startofpacket_o = 1'b0;
    src_endofpacket_o   = 1'b0;
    case (state_q)
      IDLE: begin
        // Words without SOP outside a packet are flushed; SOP words wait for the grant.
        snk_ready_o = snk_valid_i & ~snk_startofpacket_i;
        if (|pick_gnt) begin
          grant_d = pick_idx;
          state_d = PASS;
        end
      end
      PASS: begin
        src_valid_o          = g_vld;
        src_data_o           = data_arr[grant_q];
        src_startofpacket_o  = g_vld & (cnt_q == '0);
        src_endofpacket_o    = g_vld & (g_eop | (cnt_q == CNT_LAST));
        snk_ready_o[grant_q] = src_ready_i;
        if (g_vld && src_ready_i) begin
          if (g_eop) begin
            state_d = IDLE;
            cnt_d   = '0;
            ptr_d   = g_next;
          end else if (cnt_q == CNT_LAST) begin
            state_d = DROP;
            cnt_d   = '0;
            trunc_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DROP: begin
        snk_ready_o[grant_q] = 1'b1;
        if (g_vld && g_eop) begin
          state_d = IDLE;
          ptr_d   = g_next;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush-ready is input-driven, so it must be forced low while reset is held.
    if (rst_i) snk_ready_o = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  assign src_channel_o = grant_q;
  assign busy_o        = (state_q != IDLE);
  assign trunc_o       = trunc_q;

endmodule

// File: tb/tb_sort_pkt_arbiter.sv
// Scoreboard bench for sort_pkt_arbiter: per-requester word queues drive the sinks,
// per-channel expected queues are checked by an independent monitor.
module tb_sort_pkt_arbiter;

  localparam int DW = 8;
  localparam int NS = 4;
  localparam int ML = 16;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS*DW-1:0] snk_data;
  logic [NS-1:0]   snk_sop, snk_eop, snk_vld, snk_rdy;
  logic [DW-1:0]   src_data;
  logic            src_sop, src_eop, src_vld, src_rdy;
  logic [CW-1:0]   src_ch;
  logic            busy, trunc;

  always #5 clk = ~clk;

  sort_pkt_arbiter #(.DWIDTH(DW), .NUM_SRC(NS), .MAX_PKT_LEN(ML)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .snk_data_i          (snk_data),
    .snk_startofpacket_i (snk_sop),
    .snk_endofpacket_i   (snk_eop),
    .snk_valid_i         (snk_vld),
    .snk_ready_o         (snk_rdy),
    .src_data_o          (src_data),
    .src_startofpacket_o (src_sop),
    .src_endofpacket_o   (src_eop),
    .src_valid_o         (src_vld),
    .src_ready_i         (src_rdy),
    .src_channel_o       (src_ch),
    .busy_o              (busy),
    .trunc_o             (trunc)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t wq   [NS][$];
  beat_t expq [NS][$];
  int    ch_log[$];
  int    sop_cyc[$];
  int    eop_cyc[$];

  int vecs = 0, errs = 0, cyc = 0, acc_cnt = 0, tr_cnt = 0, exp_trunc = 0;
  int p_valid = 100, p_ready = 100;
  int a0, t0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: a packet of len words yields min(len,ML) output words,
  // EOP on the last of them; anything beyond ML is swallowed.
  task automatic send_pkt(input int k, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d   = DW'($urandom);
      b.sop = (i == 0);
      b.eop = (i == len - 1);
      wq[k].push_back(b);
      if (i < ML) begin
        b.eop = (i == len - 1) || (i == ML - 1);
        expq[k].push_back(b);
      end
    end
    if (len > ML) exp_trunc++;
  endtask

  task automatic send_stray(input int k);
    beat_t b;
    b.d   = DW'($urandom);
    b.sop = 1'b0;
    b.eop = 1'($urandom_range(1));
    wq[k].push_back(b);
  endtask

  function automatic bit all_done();
    for (int k = 0; k < NS; k++)
      if (wq[k].size() != 0 || expq[k].size() != 0) return 1'b0;
    return !busy;
  endfunction

  task automatic drain(input string nm, input int budget);
    int i;
    i = 0;
    while (!all_done() && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk({nm, " drain"}, 32'(all_done()), 32'd1);
  endtask

  task automatic clear_logs();
    ch_log.delete();
    sop_cyc.delete();
    eop_cyc.delete();
  endtask

  // Requester and sorter-ready driver, updated just after each rising edge.
  initial begin
    snk_data = '0;
    snk_sop  = '0;
    snk_eop  = '0;
    snk_vld  = '0;
    src_rdy  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < NS; k++) begin
        if (!rst && wq[k].size() > 0) begin
          snk_vld[k]           = (int'($urandom_range(99)) < p_valid);
          snk_data[k*DW +: DW] = wq[k][0].d;
          snk_sop[k]           = wq[k][0].sop;
          snk_eop[k]           = wq[k][0].eop;
        end else begin
          snk_vld[k] = 1'b0;
          snk_sop[k] = 1'b0;
          snk_eop[k] = 1'b0;
        end
      end
      src_rdy = (int'($urandom_range(99)) < p_ready);
    end
  end

  // Monitor: retires accepted sink words and checks every accepted source beat.
  initial begin : mon
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < NS; k++)
          if (snk_vld[k] && snk_rdy[k] && wq[k].size() > 0) wq[k].delete(0);
        if (trunc) tr_cnt++;
        if (src_vld && src_rdy) begin
          acc_cnt++;
          if (src_sop) begin
            ch_log.push_back(int'(src_ch));
            sop_cyc.push_back(cyc);
          end
          if (src_eop) eop_cyc.push_back(cyc);
          vecs++;
          if (expq[src_ch].size() == 0) begin
            errs++;
            $display("FAIL unexpected beat ch%0d: got data 0x%0h sop %0b eop %0b, expected none",
                     src_ch, src_data, src_sop, src_eop);
          end else begin
            vecs--;
            e = expq[src_ch].pop_front();
            chk($sformatf("beat ch%0d", src_ch), {22'd0, src_data, src_sop, src_eop}, {22'd0, e});
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset outputs", {13'd0, src_data, src_sop, src_eop, src_vld, snk_rdy, src_ch, busy, trunc}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("busy after reset", 32'(busy), 32'd0);

    // Simultaneous SOPs on 0 and 2, then pointer-dependent repeat.
    clear_logs();
    send_pkt(0, 3);
    send_pkt(2, 3);
    drain("two sop", 200);
    chk("gap cycles", sop_cyc[1] - eop_cyc[0], 32'd2);
    send_pkt(0, 1);
    drain("single 0", 100);
    send_pkt(0, 2);
    send_pkt(2, 2);
    drain("ptr at 1", 200);
    chk("grant count", ch_log.size(), 32'd5);
    chk("grant 0", ch_log[0], 32'd0);
    chk("grant 1", ch_log[1], 32'd2);
    chk("grant 2", ch_log[2], 32'd0);
    chk("grant 3", ch_log[3], 32'd2);
    chk("grant 4", ch_log[4], 32'd0);

    // Over-long packet on requester 1.
    t0 = tr_cnt;
    a0 = acc_cnt;
    send_pkt(1, 20);
    drain("overlong", 300);
    chk("trunc pulses", tr_cnt - t0, 32'd1);
    chk("overlong beats", acc_cnt - a0, 32'd16);

    // Stray word on requester 3 while idle, then a single-word packet.
    @(negedge clk);
    send_stray(3);
    @(negedge clk);
    chk("stray ready", 32'(snk_rdy[3]), 32'd1);
    chk("stray no src", 32'(src_vld), 32'd0);
    clear_logs();
    send_pkt(3, 1);
    drain("single word", 100);
    chk("single ch", ch_log[0], 32'd3);

    // Reset in the middle of a packet; pointer must come back to 0.
    send_pkt(1, 2);
    drain("pre reset", 100);
    a0 = acc_cnt;
    send_pkt(1, 10);
    for (int i = 0; i < 200 && acc_cnt < a0 + 4; i++) begin
      @(negedge clk);
      #1;
    end
    chk("beats before reset", acc_cnt - a0, 32'd4);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid reset outputs", {13'd0, src_data, src_sop, src_eop, src_vld, snk_rdy, src_ch, busy, trunc}, 32'd0);
    @(negedge clk);
    for (int k = 0; k < NS; k++) begin
      wq[k].delete();
      expq[k].delete();
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("busy after mid reset", 32'(busy), 32'd0);
    clear_logs();
    send_pkt(0, 1);
    send_pkt(2, 1);
    drain("post reset", 100);
    chk("fresh grant 0", ch_log[0], 32'd0);
    chk("fresh grant 1", ch_log[1], 32'd2);

    // Randomized traffic with 50% valid and 50% back-pressure.
    p_valid = 50;
    p_ready = 50;
    for (int k = 0; k < NS; k++) begin
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(3) == 0) send_stray(k);
        send_pkt(k, ($urandom_range(2) == 0) ? int'($urandom_range(20, 1)) : 10);
      end
    end
    drain("random", 20000);
    chk("total trunc pulses", tr_cnt, exp_trunc);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
